// File: rtl/dbg_bus_arbiter.sv
// dbg_bus_arbiter
//   Shares the core data-memory port between the core load/store unit and the
//   JTAG debug module memory path. The debug side only reaches the bus after
//   the core has acknowledged a halt request, and the halt is kept for as long
//   as the debug side asks for it (dbg_hold_i or back-to-back requests).
//
// Ports
//   clk, rst           core clock, synchronous active-high reset
//   core_*             core LSU request/grant/response channel
//   dbg_*              debug module request/grant/response channel, plus
//                      dbg_hold_i (keep halted) and dbg_err_o (halt timeout)
//   bus_*              single-outstanding request channel to the slave
//   halt_req_o         halt request to the core pipeline
//   halted_i           core halted with no LSU access pending
module dbg_bus_arbiter #(
    parameter int unsigned HALT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,

    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic        dbg_hold_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,

    output logic        halt_req_o,
    input  logic        halted_i
);

    typedef enum logic [2:0] {
        IDLE,
        CORE_REQ,
        CORE_WAIT,
        HALT_WAIT,
        DBG_REQ,
        DBG_WAIT,
        DBG_HOLD
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_run;
    logic w_timeout;

    // Outputs are forced quiet while reset is asserted, even mid-transaction.
    assign w_run = !rst;

    // halted_i has priority over the timeout in the same cycle.
    assign w_timeout = (r_state == HALT_WAIT) && !halted_i &&
                       (r_cnt == CNT_W'(HALT_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dbg_req_i) begin
                        r_state <= HALT_WAIT;
                    end else if (core_req_i) begin
                        r_state <= CORE_REQ;
                    end
                end
                CORE_REQ: begin
                    if (bus_gnt_i) begin
                        r_state <= CORE_WAIT;
                    end
                end
                CORE_WAIT: begin
                    if (bus_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                HALT_WAIT: begin
                    if (halted_i) begin
                        r_state <= DBG_REQ;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DBG_REQ: begin
                    if (bus_gnt_i) begin
                        r_state <= DBG_WAIT;
                    end
                end
                DBG_WAIT: begin
                    if (bus_rvalid_i) begin
                        r_state <= DBG_HOLD;
                    end
                end
                DBG_HOLD: begin
                    // Core is still halted, so a new request skips HALT_WAIT.
                    if (dbg_req_i) begin
                        r_state <= DBG_REQ;
                    end else if (!dbg_hold_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Bus mux: fields depend only on the registered state, so there is no
    // path from bus_rvalid_i to bus_req_o.
    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        if (w_run && (r_state == CORE_REQ)) begin
            bus_req_o   = 1'b1;
            bus_we_o    = core_we_i;
            bus_addr_o  = core_addr_i;
            bus_wdata_o = core_wdata_i;
        end else if (w_run && (r_state == DBG_REQ)) begin
            bus_req_o   = 1'b1;
            bus_we_o    = dbg_we_i;
            bus_addr_o  = dbg_addr_i;
            bus_wdata_o = dbg_wdata_i;
        end
    end

    assign core_gnt_o    = w_run && (r_state == CORE_REQ) && bus_gnt_i;
    assign core_rvalid_o = w_run && (r_state == CORE_WAIT) && bus_rvalid_i;
    assign core_rdata_o  = bus_rdata_i;

    // A halt timeout consumes the debug request and answers it with an error
    // response carrying zero data.
    assign dbg_gnt_o    = w_run && (((r_state == DBG_REQ) && bus_gnt_i) || w_timeout);
    assign dbg_rvalid_o = w_run && (((r_state == DBG_WAIT) && bus_rvalid_i) || w_timeout);
    assign dbg_err_o    = w_run && w_timeout;
    assign dbg_rdata_o  = w_timeout ? 32'h0 : bus_rdata_i;

    assign halt_req_o = w_run && ((r_state == HALT_WAIT) || (r_state == DBG_REQ) ||
                                  (r_state == DBG_WAIT)  || (r_state == DBG_HOLD));

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
module tb_dbg_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic        core_gnt_o, core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        dbg_req_i, dbg_we_i, dbg_hold_i;
    logic [31:0] dbg_addr_i, dbg_wdata_i;
    logic        dbg_gnt_o, dbg_rvalid_o, dbg_err_o;
    logic [31:0] dbg_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        halt_req_o, halted_i;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    dbg_bus_arbiter #(
        .HALT_TIMEOUT(4),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_gnt_o   (core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o (core_rdata_o),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_wdata_i  (dbg_wdata_i),
        .dbg_hold_i   (dbg_hold_i),
        .dbg_gnt_o    (dbg_gnt_o),
        .dbg_rvalid_o (dbg_rvalid_o),
        .dbg_rdata_o  (dbg_rdata_o),
        .dbg_err_o    (dbg_err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .halt_req_o   (halt_req_o),
        .halted_i     (halted_i)
    );

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s observed %h expected queued entry (queue empty)", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        core_req_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0; dbg_hold_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; halted_i = 0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_bus_req", 32'(bus_req_o), 0);
        chk("rst_halt", 32'(halt_req_o), 0);
        chk("rst_err", 32'(dbg_err_o), 0);

        // Core read of 0x100
        core_req_i = 1; core_addr_i = 32'h100;
        cyc();
        bus_gnt_i = 1; #1;
        chk("t1_bus_req", 32'(bus_req_o), 1);
        chk("t1_bus_addr", bus_addr_o, 32'h100);
        chk("t1_core_gnt", 32'(core_gnt_o), 1);
        chk("t1_halt", 32'(halt_req_o), 0);
        cyc();
        core_req_i = 0; bus_gnt_i = 0; sb_q.push_back(32'hDEADBEEF); #1;
        chk("t1_gnt_once", 32'(core_gnt_o), 0);
        chk("t1_req_drop", 32'(bus_req_o), 0);
        cyc();
        bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF; #1;
        chk("t1_core_rvalid", 32'(core_rvalid_o), 1);
        sb_pop("t1_core_rdata", core_rdata_o);
        chk("t1_dbg_rvalid", 32'(dbg_rvalid_o), 0);
        cyc();
        bus_rvalid_i = 0; #1;
        chk("t1_halt_end", 32'(halt_req_o), 0);

        // Simultaneous requests: debug first, then core
        core_req_i = 1; core_addr_i = 32'h300;
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 32'h200; dbg_wdata_i = 32'h55; dbg_hold_i = 1;
        cyc();
        bus_gnt_i = 1; #1;
        chk("t2_halt", 32'(halt_req_o), 1);
        chk("t2_hw_bus_req", 32'(bus_req_o), 0);
        chk("t2_hw_core_gnt", 32'(core_gnt_o), 0);
        chk("t2_hw_dbg_gnt", 32'(dbg_gnt_o), 0);
        cyc(); cyc(); cyc();
        halted_i = 1; #1;
        chk("t2_no_err", 32'(dbg_err_o), 0);
        cyc();
        #1;
        chk("t2_bus_req", 32'(bus_req_o), 1);
        chk("t2_bus_we", 32'(bus_we_o), 1);
        chk("t2_bus_addr", bus_addr_o, 32'h200);
        chk("t2_bus_wdata", bus_wdata_o, 32'h55);
        chk("t2_dbg_gnt", 32'(dbg_gnt_o), 1);
        chk("t2_core_gnt", 32'(core_gnt_o), 0);
        cyc();
        dbg_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h0;
        sb_q.push_back(32'h0); #1;
        chk("t2_dbg_rvalid", 32'(dbg_rvalid_o), 1);
        sb_pop("t2_dbg_rdata", dbg_rdata_o);
        chk("t2_core_rvalid", 32'(core_rvalid_o), 0);
        cyc();
        bus_rvalid_i = 0; #1;
        chk("t2_hold_halt", 32'(halt_req_o), 1);
        chk("t2_hold_bus_req", 32'(bus_req_o), 0);
        cyc();
        dbg_hold_i = 0; #1;
        chk("t2_hold_halt2", 32'(halt_req_o), 1);
        cyc();
        halted_i = 0; #1;
        chk("t2_idle_halt", 32'(halt_req_o), 0);
        cyc();
        bus_gnt_i = 1; #1;
        chk("t2_core_gnt2", 32'(core_gnt_o), 1);
        chk("t2_core_addr", bus_addr_o, 32'h300);
        cyc();
        core_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h12345678;
        sb_q.push_back(32'h12345678); #1;
        chk("t2_core_rvalid2", 32'(core_rvalid_o), 1);
        sb_pop("t2_core_rdata2", core_rdata_o);
        cyc();
        bus_rvalid_i = 0;

        // Debug request arriving during CORE_WAIT
        core_req_i = 1; core_we_i = 0; core_addr_i = 32'h400;
        cyc();
        bus_gnt_i = 1; #1;
        chk("t3_core_gnt", 32'(core_gnt_o), 1);
        cyc();
        core_req_i = 0; bus_gnt_i = 0;
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 32'h500; dbg_hold_i = 0; #1;
        chk("t3_halt_cw1", 32'(halt_req_o), 0);
        cyc();
        bus_rvalid_i = 1; bus_rdata_i = 32'hCAFE0001; sb_q.push_back(32'hCAFE0001); #1;
        chk("t3_halt_cw2", 32'(halt_req_o), 0);
        chk("t3_core_rvalid", 32'(core_rvalid_o), 1);
        chk("t3_dbg_rvalid", 32'(dbg_rvalid_o), 0);
        sb_pop("t3_core_rdata", core_rdata_o);
        cyc();
        bus_rvalid_i = 0; #1;
        chk("t3_idle_halt", 32'(halt_req_o), 0);
        cyc();
        #1;
        chk("t3_hw_halt", 32'(halt_req_o), 1);
        halted_i = 1;
        cyc();
        bus_gnt_i = 1; #1;
        chk("t3_dbg_gnt", 32'(dbg_gnt_o), 1);
        chk("t3_dbg_addr", bus_addr_o, 32'h500);
        cyc();
        dbg_req_i = 0; bus_gnt_i = 0;
        cyc();
        bus_rvalid_i = 1; bus_rdata_i = 32'h0000A5A5; sb_q.push_back(32'h0000A5A5); #1;
        chk("t3_dbg_rvalid2", 32'(dbg_rvalid_o), 1);
        sb_pop("t3_dbg_rdata", dbg_rdata_o);
        cyc();
        bus_rvalid_i = 0; halted_i = 0;
        cyc();

        // Halt timeout with HALT_TIMEOUT = 4
        dbg_req_i = 1; dbg_addr_i = 32'h700; bus_gnt_i = 1; bus_rdata_i = 32'hFFFFFFFF;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_err_early", 32'(dbg_err_o), 0);
            chk("t4_bus_req", 32'(bus_req_o), 0);
            chk("t4_halt", 32'(halt_req_o), 1);
            cyc();
        end
        #1;
        chk("t4_err", 32'(dbg_err_o), 1);
        chk("t4_rvalid", 32'(dbg_rvalid_o), 1);
        chk("t4_gnt", 32'(dbg_gnt_o), 1);
        chk("t4_rdata_zero", dbg_rdata_o, 32'h0);
        chk("t4_bus_req_last", 32'(bus_req_o), 0);
        cyc();
        dbg_req_i = 0; #1;
        chk("t4_halt_drop", 32'(halt_req_o), 0);
        chk("t4_err_drop", 32'(dbg_err_o), 0);
        chk("t4_bus_req_idle", 32'(bus_req_o), 0);
        bus_gnt_i = 0;

        // Back-to-back debug reads with hold
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 32'h600; dbg_hold_i = 1;
        cyc();
        halted_i = 1; #1;
        chk("t5_halt_hw", 32'(halt_req_o), 1);
        cyc();
        bus_gnt_i = 1; #1;
        chk("t5_gnt1", 32'(dbg_gnt_o), 1);
        chk("t5_halt_r1", 32'(halt_req_o), 1);
        cyc();
        dbg_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h11;
        sb_q.push_back(32'h11); #1;
        chk("t5_rvalid1", 32'(dbg_rvalid_o), 1);
        sb_pop("t5_rdata1", dbg_rdata_o);
        cyc();
        bus_rvalid_i = 0; dbg_req_i = 1; dbg_addr_i = 32'h604; #1;
        chk("t5_halt_hold", 32'(halt_req_o), 1);
        cyc();
        bus_gnt_i = 1; #1;
        chk("t5_halt_r2", 32'(halt_req_o), 1);
        chk("t5_bus_req2", 32'(bus_req_o), 1);
        chk("t5_addr2", bus_addr_o, 32'h604);
        chk("t5_gnt2", 32'(dbg_gnt_o), 1);
        cyc();
        dbg_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h22;
        sb_q.push_back(32'h22); #1;
        chk("t5_rvalid2", 32'(dbg_rvalid_o), 1);
        sb_pop("t5_rdata2", dbg_rdata_o);
        cyc();
        bus_rvalid_i = 0; #1;
        chk("t5_halt_end", 32'(halt_req_o), 1);

        // Reset during DBG_WAIT, then a late response
        dbg_req_i = 1; dbg_addr_i = 32'h608;
        cyc();
        bus_gnt_i = 1; #1;
        chk("t6_gnt", 32'(dbg_gnt_o), 1);
        cyc();
        dbg_req_i = 0; bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'h99; rst = 1; #1;
        chk("t6_rst_rvalid", 32'(dbg_rvalid_o), 0);
        chk("t6_rst_gnt", 32'(dbg_gnt_o), 0);
        chk("t6_rst_bus_req", 32'(bus_req_o), 0);
        cyc();
        rst = 0; bus_gnt_i = 0; dbg_hold_i = 0; halted_i = 0; #1;
        chk("t6_late_dbg_rvalid", 32'(dbg_rvalid_o), 0);
        chk("t6_late_core_rvalid", 32'(core_rvalid_o), 0);
        chk("t6_halt", 32'(halt_req_o), 0);
        chk("t6_err", 32'(dbg_err_o), 0);
        chk("t6_bus_req", 32'(bus_req_o), 0);
        cyc();
        bus_rvalid_i = 0; #1;
        chk("t6_idle_halt", 32'(halt_req_o), 0);
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dbg_bus_arbiter.md
Name: dbg_bus_arbiter

Overview:
- Shares the single core data-memory port between the CPU load/store unit (core requester) and the JTAG debug module memory path (debug requester).
- Before the debug requester gets the bus, the core is halted via a halt request/acknowledge handshake. The halt is held for as long as the debug side requests it.
- Sits between the core LSU, the JTAG DM mem interface and the bus/RAM slave. Runs in the core clock domain; the DM side is already synchronised.

Parameters:
- HALT_TIMEOUT, 255: maximum cycles spent in HALT_WAIT before the debug access is aborted with an error.
- CNT_W, 8: width of the halt-timeout counter; must satisfy HALT_TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  core clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- core_req_i  in  1  core access request; held until core_gnt_o.
- core_we_i  in  1  core write enable.
- core_addr_i  in  32  core address.
- core_wdata_i  in  32  core write data.
- core_gnt_o  out  1  core request accepted this cycle.
- core_rvalid_o  out  1  core response valid (1-cycle pulse).
- core_rdata_o  out  32  core read data.
- dbg_req_i  in  1  debug access request; held until dbg_gnt_o.
- dbg_we_i  in  1  debug write enable.
- dbg_addr_i  in  32  debug address.
- dbg_wdata_i  in  32  debug write data.
- dbg_hold_i  in  1  debug wants the core kept halted between accesses.
- dbg_gnt_o  out  1  debug request accepted.
- dbg_rvalid_o  out  1  debug response valid (1-cycle pulse).
- dbg_rdata_o  out  32  debug read data.
- dbg_err_o  out  1  1-cycle pulse: halt timeout, debug access aborted.
- bus_req_o  out  1  request to the slave.
- bus_we_o  out  1  slave write enable.
- bus_addr_o  out  32  slave address.
- bus_wdata_o  out  32  slave write data.
- bus_gnt_i  in  1  slave accepts request (handshake on bus_req_o & bus_gnt_i).
- bus_rvalid_i  in  1  slave response valid; arrives ≥1 cycle after the accept.
- bus_rdata_i  in  32  slave read data.
- halt_req_o  out  1  halt request to the core pipeline.
- halted_i  in  1  core reports it is halted with no LSU access pending.

Behaviour:
- States: IDLE, CORE_REQ, CORE_WAIT, HALT_WAIT, DBG_REQ, DBG_WAIT, DBG_HOLD.
- Transaction rule: at most one bus transaction is outstanding. The owner does not change between accept and rvalid.
- Mux: the bus_* outputs take the core fields in CORE_REQ and the debug fields in DBG_REQ. In all other states they are driven to 0.
- Grants: core_gnt_o = bus_gnt_i in CORE_REQ. dbg_gnt_o = bus_gnt_i in DBG_REQ. Both are combinational.
- Read data: core_rdata_o and dbg_rdata_o both carry bus_rdata_i.
- Response routing: core_rvalid_o = bus_rvalid_i in CORE_WAIT. dbg_rvalid_o = bus_rvalid_i in DBG_WAIT, plus the abort pulse (see HALT_WAIT). bus_rvalid_i in any other state is ignored.
- IDLE:
  - dbg_req_i → HALT_WAIT. Debug has priority when both requests are present in the same cycle.
  - Else core_req_i → CORE_REQ.
- CORE_REQ: on accept → CORE_WAIT.
- CORE_WAIT: on bus_rvalid_i → IDLE. A debug request arriving during CORE_* waits until the core transaction completes.
- HALT_WAIT:
  - halt_req_o = 1; the counter increments each cycle.
  - halted_i → DBG_REQ; counter is cleared.
  - Counter == HALT_TIMEOUT with halted_i still 0: pulse dbg_err_o and dbg_rvalid_o together (dbg_rdata_o forced to 0 that cycle), pulse dbg_gnt_o in the same cycle to consume the request, clear the counter, drop halt_req_o → IDLE.
  - halted_i and timeout in the same cycle: halted_i wins.
- DBG_REQ: on accept → DBG_WAIT.
- DBG_WAIT: on bus_rvalid_i → DBG_HOLD.
- DBG_HOLD:
  - dbg_req_i → DBG_REQ directly, with no re-halt.
  - Else !dbg_hold_i → IDLE.
  - Else stay.
- halt_req_o is 1 in HALT_WAIT, DBG_REQ, DBG_WAIT and DBG_HOLD. It drops the cycle the FSM registers IDLE.
- halted_i dropping while halt_req_o = 1 is a protocol violation; the FSM ignores it.
- Reset, including mid-transaction: state = IDLE, counter = 0, halt_req_o = 0, dbg_err_o = 0. All bus_*, gnt and rvalid outputs are 0 during and after reset. A late bus_rvalid_i after reset is dropped.
- No combinational path from bus_rvalid_i to bus_req_o.

Test Plan:
- Core read: core_req_i = 1, addr 0x100, slave grants in cycle 1 and returns rvalid with 0xDEADBEEF 2 cycles later → core_gnt_o pulses once, core_rvalid_o = 1 with core_rdata_o = 0xDEADBEEF, halt_req_o stays 0.
- Simultaneous requests in IDLE, halted_i rising 3 cycles after halt_req_o → HALT_WAIT, debug write 0x55 to 0x200 is issued on the bus, then DBG_HOLD; after dbg_hold_i = 0, the core request is served next.
- Debug request during CORE_WAIT → no halt_req_o until the core rvalid; the core response is not redirected to debug.
- HALT_TIMEOUT = 4 with halted_i held at 0 → dbg_err_o, dbg_rvalid_o and dbg_gnt_o pulse on the 5th HALT_WAIT cycle, halt_req_o = 0 the next cycle, bus_req_o never asserted.
- Back-to-back debug reads with dbg_hold_i = 1 → halt_req_o stays continuously 1, no second HALT_WAIT entry, two bus transactions.
- rst asserted in DBG_WAIT → all outputs 0 next cycle; a late bus_rvalid_i produces no dbg_rvalid_o and no core_rvalid_o.
